// File: rtl/se_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | se_pkg : shared constants and state type for the SE channel-scale stage  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package se_pkg;

    localparam int DATA_WIDTH = 14;
    localparam int FRAC_BITS  = 9;
    localparam int GATE_ONE   = 1 << FRAC_BITS;
    localparam int RND_HALF   = 1 << (FRAC_BITS - 1);
    localparam int SAT_MAX    = (1 << (DATA_WIDTH - 1)) - 1;
    localparam int SAT_MIN    = -(1 << (DATA_WIDTH - 1));

    typedef enum logic [0:0] {
        LOAD  = 1'b0,
        SCALE = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/se_channel_scale_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | se_channel_scale_if : gate load, feature stream and scaled output bus    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface se_channel_scale_if #(
    parameter int DATA_WIDTH = se_pkg::DATA_WIDTH
);
    logic        [DATA_WIDTH-1:0] gate_in;
    logic                         gate_valid;
    logic signed [DATA_WIDTH-1:0] feat_in;
    logic                         feat_valid;
    logic                         feat_ready;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_valid;
    logic                         gates_loaded;
    logic                         done;

    modport master (
        output gate_in, gate_valid, feat_in, feat_valid,
        input  feat_ready, out_data, out_valid, gates_loaded, done
    );

    modport slave (
        input  gate_in, gate_valid, feat_in, feat_valid,
        output feat_ready, out_data, out_valid, gates_loaded, done
    );
endinterface
`default_nettype wire

// File: rtl/se_gate_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | se_gate_buffer : per-channel gate register file, self-addressed writes   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module se_gate_buffer #(
    parameter int DATA_WIDTH = 14,
    parameter int NUM_CH     = 16,
    localparam int AW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  wr_en,
    input  wire logic [DATA_WIDTH-1:0] wr_data,
    input  wire logic [AW-1:0]         rd_addr,
    output logic      [DATA_WIDTH-1:0] rd_data,
    output logic                       wr_last
);

    logic [DATA_WIDTH-1:0] r_mem [NUM_CH];
    logic [AW-1:0]         r_wr_ptr;

    assign wr_last = wr_en && (r_wr_ptr == AW'(NUM_CH - 1));
    assign rd_data = r_mem[rd_addr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
        end else if (wr_en) begin
            r_wr_ptr <= wr_last ? '0 : r_wr_ptr + AW'(1);
        end
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/se_channel_scale.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | se_channel_scale : load per-channel SE gates, then scale feature stream  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module se_channel_scale #(
    parameter int DATA_WIDTH = se_pkg::DATA_WIDTH,
    parameter int FRAC_BITS  = se_pkg::FRAC_BITS,
    parameter int NUM_CH     = 16,
    parameter int NUM_PIX    = 49
) (
    input  wire logic          clk,
    input  wire logic          rst,
    se_channel_scale_if.slave  bus
);
    import se_pkg::*;

    localparam int CW = (NUM_CH  > 1) ? $clog2(NUM_CH)  : 1;
    localparam int XW = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam int PW = 2 * DATA_WIDTH;

    localparam logic signed [PW-1:0] C_RND     = PW'(1) << (FRAC_BITS - 1);
    localparam logic signed [PW-1:0] C_SAT_MAX = (PW'(1) << (DATA_WIDTH - 1)) - PW'(1);
    localparam logic signed [PW-1:0] C_SAT_MIN = ~C_SAT_MAX;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic        [CW-1:0]         r_ch;
    logic        [XW-1:0]         r_pix;
    logic                         w_accept;
    logic                         w_ch_last;
    logic                         w_img_last;
    logic                         w_gate_wr;
    logic                         w_wr_last;
    logic        [DATA_WIDTH-1:0] w_gate_rd;

    logic                         r_v1;
    logic                         r_last1;
    logic signed [DATA_WIDTH-1:0] r_feat1;
    logic        [DATA_WIDTH-1:0] r_gate1;
    logic                         r_v2;
    logic                         r_last2;
    logic signed [PW-1:0]         r_prod2;
    logic                         r_v3;
    logic                         r_done3;
    logic signed [DATA_WIDTH-1:0] r_out3;

    logic signed [PW-1:0]         w_feat_ext;
    logic signed [PW-1:0]         w_gate_ext;
    logic signed [PW-1:0]         w_prod;
    logic signed [PW-1:0]         w_rnd;
    logic signed [PW-1:0]         w_shift;
    logic signed [DATA_WIDTH-1:0] w_sat;

    assign w_gate_wr  = bus.gate_valid && (r_state == LOAD);
    assign w_accept   = bus.feat_valid && (r_state == SCALE);
    assign w_ch_last  = (r_ch == CW'(NUM_CH - 1));
    assign w_img_last = w_accept && w_ch_last && (r_pix == XW'(NUM_PIX - 1));

    se_gate_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_CH     (NUM_CH)
    ) u_gate_buffer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_gate_wr),
        .wr_data (bus.gate_in),
        .rd_addr (r_ch),
        .rd_data (w_gate_rd),
        .wr_last (w_wr_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        bus.feat_ready   = 1'b0;
        bus.gates_loaded = 1'b0;
        case (r_state)
            LOAD: begin
                if (w_wr_last) w_state_nxt = SCALE;
            end
            SCALE: begin
                bus.feat_ready   = 1'b1;
                bus.gates_loaded = 1'b1;
                if (w_img_last) w_state_nxt = LOAD;
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ch  <= '0;
            r_pix <= '0;
        end else if (w_accept) begin
            if (w_ch_last) begin
                r_ch  <= '0;
                r_pix <= w_img_last ? '0 : r_pix + XW'(1);
            end else begin
                r_ch  <= r_ch + CW'(1);
            end
        end
    end

    // Gate is zero-extended so the full 0..2^DATA_WIDTH-1 range multiplies as positive.
    assign w_feat_ext = {{DATA_WIDTH{r_feat1[DATA_WIDTH-1]}}, r_feat1};
    assign w_gate_ext = {{DATA_WIDTH{1'b0}}, r_gate1};
    assign w_prod     = w_feat_ext * w_gate_ext;
    assign w_rnd      = r_prod2 + C_RND;
    assign w_shift    = w_rnd >>> FRAC_BITS;

    always_comb begin
        w_sat = w_shift[DATA_WIDTH-1:0];
        if (w_shift > C_SAT_MAX) begin
            w_sat = C_SAT_MAX[DATA_WIDTH-1:0];
        end else if (w_shift < C_SAT_MIN) begin
            w_sat = C_SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
            r_feat1 <= '0;
            r_gate1 <= '0;
            r_v2    <= 1'b0;
            r_last2 <= 1'b0;
            r_prod2 <= '0;
            r_v3    <= 1'b0;
            r_done3 <= 1'b0;
            r_out3  <= '0;
        end else begin
            r_v1    <= w_accept;
            r_last1 <= w_img_last;
            if (w_accept) begin
                r_feat1 <= bus.feat_in;
                r_gate1 <= w_gate_rd;
            end
            r_v2    <= r_v1;
            r_last2 <= r_last1;
            r_prod2 <= w_prod;
            r_v3    <= r_v2;
            r_done3 <= r_v2 && r_last2;
            r_out3  <= r_v2 ? w_sat : '0;
        end
    end

    assign bus.out_valid = r_v3;
    assign bus.out_data  = r_out3;
    assign bus.done      = r_done3;

endmodule
`default_nettype wire

// File: tb/tb_se_channel_scale.sv
`default_nettype none
// Randomized scoreboard bench for se_channel_scale: a behavioural model predicts
// every scaled word at issue time; a negedge monitor pops and compares outputs.
module tb_se_channel_scale;

    localparam int DW   = 14;
    localparam int FB   = 9;
    localparam int NCH  = 16;
    localparam int NPIX = 49;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    se_channel_scale_if #(.DATA_WIDTH(DW)) bus();

    se_channel_scale #(
        .DATA_WIDTH (DW),
        .FRAC_BITS  (FB),
        .NUM_CH     (NCH),
        .NUM_PIX    (NPIX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        longint data;
        bit     last;
        int     cyc;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;

    bit     m_scale = 1'b0;
    int     m_wp    = 0;
    int     m_ch    = 0;
    int     m_pix   = 0;
    longint m_gates[NCH];
    longint gs[NCH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // round(f*g / 2^FB) with ties toward +inf, then clamp to the signed word range
    function automatic longint ref_scale(input longint f, input longint g);
        longint num, q;
        num = f * g + (longint'(1) << (FB - 1));
        q   = num / (longint'(1) << FB);
        if (num < 0 && (num % (longint'(1) << FB)) != 0) q = q - 1;
        if (q > (longint'(1) << (DW - 1)) - 1) q = (longint'(1) << (DW - 1)) - 1;
        if (q < -(longint'(1) << (DW - 1)))    q = -(longint'(1) << (DW - 1));
        return q;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_data", bus.out_data, mon_e.data);
                    check("done", bus.done, mon_e.last);
                    check("latency", cyc - mon_e.cyc, 3);
                end
            end else begin
                check("idle_out_data", bus.out_data, 0);
                check("idle_done", bus.done, 0);
            end
        end
    end

    task automatic step(input bit gv, input longint g, input bit fv, input longint f);
        exp_t e;
        @(posedge clk);
        #1;
        bus.gate_valid = gv;
        bus.gate_in    = DW'(g);
        bus.feat_valid = fv;
        bus.feat_in    = DW'(f);
        check("feat_ready", bus.feat_ready, m_scale);
        check("gates_loaded", bus.gates_loaded, m_scale);
        if (m_scale) begin
            if (fv) begin
                e.data = ref_scale(f, m_gates[m_ch]);
                e.last = (m_ch == NCH - 1) && (m_pix == NPIX - 1);
                e.cyc  = cyc;
                sb.push_back(e);
                if (m_ch == NCH - 1) begin
                    m_ch = 0;
                    if (m_pix == NPIX - 1) begin
                        m_pix   = 0;
                        m_scale = 1'b0;
                    end else begin
                        m_pix++;
                    end
                end else begin
                    m_ch++;
                end
            end
        end else if (gv) begin
            m_gates[m_wp] = g;
            if (m_wp == NCH - 1) begin
                m_wp    = 0;
                m_scale = 1'b1;
            end else begin
                m_wp++;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst            = 1'b0;
        bus.gate_valid = 1'b0;
        bus.feat_valid = 1'b0;
        sb.delete();
        m_scale = 1'b0;
        m_wp    = 0;
        m_ch    = 0;
        m_pix   = 0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_done", bus.done, 0);
        check("rst_feat_ready", bus.feat_ready, 0);
        check("rst_gates_loaded", bus.gates_loaded, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Feature words offered during LOAD must be dropped by the design.
    task automatic load_gates(input longint g[NCH], input bit gaps);
        bit gv;
        for (int t = 0; t < 1000 && !m_scale; t++) begin
            gv = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            step(gv, g[m_wp], 1'($urandom_range(0, 1)),
                 longint'($urandom_range(0, 16383)) - 8192);
        end
        if (!m_scale) check("load_timeout", 0, 1);
    endtask

    // Gate words offered during SCALE must be dropped by the design.
    task automatic scale_image(input int kind, input bit hold, input bit abort);
        bit     fv;
        longint f;
        for (int t = 0; t < 4000 && m_scale; t++) begin
            if (abort && m_pix == 10 && m_ch == 5) begin
                do_reset();
                return;
            end
            fv = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
            f  = longint'($urandom_range(0, 16383)) - 8192;
            if (kind == 0) begin
                f = (m_ch == 0) ? 1024 : (m_ch == 1) ? -700 : 100;
            end else if (kind == 1) begin
                case (m_ch)
                    0: f = 3;
                    1: f = -3;
                    2: f = 1;
                    3: f = 255;
                    default: ;
                endcase
            end
            step(1'($urandom_range(0, 1)), longint'($urandom_range(0, 16383)), fv, f);
        end
        if (m_scale) check("scale_timeout", 0, 1);
    endtask

    initial begin
        bus.gate_valid = 1'b0;
        bus.gate_in    = '0;
        bus.feat_valid = 1'b0;
        bus.feat_in    = '0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_feat_ready", bus.feat_ready, 0);
        check("reset_gates_loaded", bus.gates_loaded, 0);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_out_data", bus.out_data, 0);
        check("reset_done", bus.done, 0);
        rst = 1'b1;

        // Directed image: ch0 half gate, ch1 unity, others closed.
        for (int i = 0; i < NCH; i++) gs[i] = 0;
        gs[0] = 256;
        gs[1] = 512;
        load_gates(gs, 1'b0);
        scale_image(0, 1'b1, 1'b0);

        // Next gates stream straight in while the previous image drains.
        for (int i = 0; i < NCH; i++) gs[i] = longint'($urandom_range(0, 512));
        load_gates(gs, 1'b0);
        scale_image(2, 1'b0, 1'b0);

        // Rounding corners on channels 0..3.
        for (int i = 0; i < NCH; i++) gs[i] = longint'($urandom_range(0, 512));
        gs[0] = 256;
        gs[1] = 256;
        gs[2] = 256;
        gs[3] = 1;
        load_gates(gs, 1'b1);
        scale_image(1, 1'b1, 1'b0);

        // Abort with reset at pixel 10, then a fresh image.
        for (int i = 0; i < NCH; i++) gs[i] = longint'($urandom_range(0, 512));
        load_gates(gs, 1'b1);
        scale_image(2, 1'b1, 1'b1);
        for (int i = 0; i < NCH; i++) gs[i] = longint'($urandom_range(0, 512));
        load_gates(gs, 1'b1);
        scale_image(2, 1'b1, 1'b0);

        // Oversized gates drive the result into saturation.
        for (int i = 0; i < NCH; i++) gs[i] = longint'($urandom_range(0, 16383));
        load_gates(gs, 1'b0);
        scale_image(2, 1'b0, 1'b0);

        repeat (8) step(1'b0, 0, 1'b0, 0);
        check("drain_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/se_channel_scale.md
# se_channel_scale

Final stage of the SE block. It captures the per-channel hard-sigmoid gates produced by the `hs_segment` stage into a local gate buffer. It then rescales the incoming feature-map stream by `gate[channel]`, producing the SE-weighted activation that goes to the next MobileNetV3 layer. Each image runs through a LOAD phase (gates) followed by a SCALE phase (NUM_PIX × NUM_CH feature words), and then the block re-arms.

## Interface
- `DATA_WIDTH`, default 14: feature, gate and output word width, signed fixed point.
- `FRAC_BITS`, default 9: fractional bits; 1.0 = 512.
- `NUM_CH`, default 16: channels per image, which is also the gate buffer depth.
- `NUM_PIX`, default 49: spatial positions per image.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `gate_in`  in  DATA_WIDTH: gate value, range 0..512, from the `hs_segment` output.
- `gate_valid`  in  1: qualifies `gate_in`.
- `feat_in`  in  DATA_WIDTH signed: feature word, channel-interleaved (pixel-major, channel 0..NUM_CH-1).
- `feat_valid`  in  1: qualifies `feat_in`.
- `feat_ready`  out  1: block accepts a feature word this cycle.
- `out_data`  out  DATA_WIDTH signed: scaled feature.
- `out_valid`  out  1: qualifies `out_data`.
- `gates_loaded`  out  1: high while in SCALE.
- `done`  out  1: one-cycle pulse coinciding with the last output of the image.

## Operation
- FSM states:
  - LOAD (entered from reset): each `gate_valid` writes `gate_in` to `gate_mem[wr_ptr]` and increments `wr_ptr`. The write at `wr_ptr == NUM_CH-1` clears `wr_ptr` and moves the FSM to SCALE on the next edge.
  - SCALE: `feat_ready` = 1. Each accepted word (`feat_valid & feat_ready`) uses `gate_mem[ch_cnt]`.
    - `ch_cnt` wraps at NUM_CH-1 and increments `pix_cnt` on the wrap.
    - Accepting the word at `ch_cnt == NUM_CH-1` and `pix_cnt == NUM_PIX-1` clears both counters and returns the FSM to LOAD.
- `gate_valid` in SCALE is ignored (no write, no pointer change). `feat_valid` in LOAD is not accepted, since `feat_ready` = 0.
- Gates for the next image may load while the previous image's pipeline drains. This is safe because the gate is read at acceptance time.
- Arithmetic:
  - Product is `feat` × `gate`, a signed 2·DATA_WIDTH-bit result (gate zero-extended).
  - Add 2^(FRAC_BITS-1), then arithmetic right shift by FRAC_BITS (round half up).
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- `done` is carried down the pipeline alongside the last accepted word's valid bit.

## Timing
- Reset values: `feat_ready`=0, `gates_loaded`=0, `out_valid`=0, `out_data`=0, `done`=0. Counters, pointers and FSM go to LOAD; `gate_mem` contents are don't-care.
- Pipeline stages:
  - S1 registers `feat` and the gate read.
  - S2 registers the product.
  - S3 registers the rounded, saturated result.
- Latency: an accept at edge N produces `out_valid` at edge N+3. Throughput is one word per cycle, with no bubbles across pixel wraps.
- `out_valid` is high only in cycles fed by an accept. `out_data` holds 0 when not valid.
- No downstream backpressure; the consumer must always accept.
- LOAD→SCALE: `feat_ready` rises in the cycle after the last gate write. SCALE→LOAD: `feat_ready` falls in the cycle after the last accept.
- Reset mid-image aborts the image immediately: the pipeline is flushed, no `done` is asserted, and the FSM returns to LOAD with `wr_ptr`=0.

## Structure
- Shared package `se_pkg` holds:
  - `DATA_WIDTH`, `FRAC_BITS`;
  - `GATE_ONE` = 512, `RND_HALF` = 256;
  - the state enum {LOAD, SCALE};
  - the saturation bounds.
- One sub-module, `se_gate_buffer`: NUM_CH × DATA_WIDTH register file with a synchronous write port, a combinational read port, and its own `wr_ptr`.
- The FSM, counters and 3-stage datapath live in the top level.

## Test plan
- Load gates ch0=256, ch1=512, others=0; feed feat ch0=1024, ch1=-700, others=100. Expected outputs: 512, -700, then 0 for the remaining channels; `out_valid` exactly 3 cycles after each accept.
- Rounding: gate=256 with feat=3 gives 2; with feat=-3 gives -1; with feat=1 gives 1. Gate=1 with feat=255 gives 0.
- Full image at NUM_CH=16, NUM_PIX=49, `feat_valid` held high: 784 back-to-back outputs, channel gate applied per wrap, `done` on the 784th output only, then `feat_ready`=0 and the FSM is in LOAD.
- Gate words sent during SCALE and feature words sent during LOAD are dropped. Gate buffer contents and counters are unchanged, verified by the next image's outputs.
- Next image's gates streamed while the previous pipeline drains: last three outputs use the old gates; the first output of the new image uses the new gates.
- Reset asserted mid-SCALE (pixel 10): all outputs are 0 asynchronously, `done` never pulses, and a fresh LOAD then SCALE completes correctly.
